// File: rtl/ob_pkg.sv
// Shared order-book types: the command word that moves between dispatcher,
// conditional table and matching engine, plus table sizing defaults.
package ob_pkg;

  typedef enum logic [3:0] {
    OP_NOP             = 4'd0,
    OP_BUY_LIMIT       = 4'd1,
    OP_SELL_LIMIT      = 4'd2,
    OP_BUY_MARKET      = 4'd3,
    OP_SELL_MARKET     = 4'd4,
    OP_BUY_STOP_LOSS   = 4'd5,
    OP_SELL_STOP_LOSS  = 4'd6,
    OP_BUY_STOP_LIMIT  = 4'd7,
    OP_SELL_STOP_LIMIT = 4'd8
  } op_t;

  typedef struct packed {
    op_t         op;
    logic [15:0] id;
    logic [31:0] price;
    logic [15:0] qty;
  } cmd_t;

  localparam int CN_TABLE_N_DEFAULT = 4;

endpackage

// File: rtl/ob_cn_table_sched_if.sv
// Bundle of the dispatcher, entry-bank and matching-engine handshakes seen by
// the conditional-table controller; master is the controller side.
interface ob_cn_table_sched_if
  import ob_pkg::*;
#(
  parameter int N = CN_TABLE_N_DEFAULT
);

  logic         in_vld;
  cmd_t         in_cmd;
  logic         in_rdy;

  logic [N-1:0] ent_busy_r;
  logic [N-1:0] ent_mtr_r;
  cmd_t         ent_cmd_r [N];
  logic [N-1:0] ent_al_vld;
  cmd_t         ent_al_cmd;
  logic [N-1:0] ent_dl_vld;

  logic         out_vld;
  cmd_t         out_cmd;
  logic         out_rdy;

  modport master (
    input  in_vld, in_cmd, ent_busy_r, ent_mtr_r, ent_cmd_r, out_rdy,
    output in_rdy, ent_al_vld, ent_al_cmd, ent_dl_vld, out_vld, out_cmd
  );

  modport slave (
    output in_vld, in_cmd, ent_busy_r, ent_mtr_r, ent_cmd_r, out_rdy,
    input  in_rdy, ent_al_vld, ent_al_cmd, ent_dl_vld, out_vld, out_cmd
  );

endinterface

// File: rtl/ob_cn_table_sched_rr_arb.sv
// N-way rotating-priority arbiter: the request at index ptr_i has top priority,
// then ptr_i+1 and so on, wrapping modulo N.
module ob_cn_rr_arb #(
  parameter int N     = 4,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [PTR_W-1:0] idx_o,
  output logic             any_o
);

  int  j;
  logic found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr_i) + k) % N;
      if (!found && req_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = PTR_W'(j);
      end
    end
  end

  assign any_o = found;

endmodule

// File: rtl/ob_cn_table_sched.sv
// Conditional-order table controller: allocates stop commands to free entries,
// round-robins matured entries into a registered reissue port, frees each entry as it loads.
module ob_cn_table_sched
  import ob_pkg::*;
#(
  parameter int N     = CN_TABLE_N_DEFAULT,
  parameter int CNT_W = $clog2(N + 1)
) (
  input  logic                clk,
  input  logic                rst,
  ob_cn_table_sched_if.master bus,
  output logic [CNT_W-1:0]    occ_r,
  output logic                full_r,
  output logic                empty_r
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]     free_oh;
  logic             free_found;
  logic             alloc;
  logic             dealloc;
  logic             load;
  logic [N-1:0]     mtr_gnt;
  logic [PTR_W-1:0] sel_idx;
  logic             any_mtr;

  logic             out_vld_q, out_vld_d;
  cmd_t             out_cmd_q, out_cmd_d;
  logic [PTR_W-1:0] rr_ptr_q,  rr_ptr_d;
  logic [CNT_W-1:0] occ_q,     occ_d;
  logic             full_q,    full_d;
  logic             empty_q,   empty_d;

  always_comb begin
    free_oh    = '0;
    free_found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!free_found && !bus.ent_busy_r[i]) begin
        free_oh[i] = 1'b1;
        free_found = 1'b1;
      end
    end
  end

  assign bus.in_rdy     = |(~bus.ent_busy_r);
  assign alloc          = bus.in_vld & bus.in_rdy & ~rst;
  assign bus.ent_al_vld = alloc ? free_oh : '0;
  assign bus.ent_al_cmd = bus.in_cmd;

  ob_cn_rr_arb #(
    .N     (N),
    .PTR_W (PTR_W)
  ) u_arb (
    .req_i (bus.ent_mtr_r),
    .ptr_i (rr_ptr_q),
    .gnt_o (mtr_gnt),
    .idx_o (sel_idx),
    .any_o (any_mtr)
  );

  // Selection uses registered matured flags, so an entry freed this cycle is never picked twice.
  assign load           = any_mtr & (~out_vld_q | bus.out_rdy);
  assign dealloc        = load & ~rst;
  assign bus.ent_dl_vld = dealloc ? mtr_gnt : '0;

  always_comb begin
    out_vld_d = out_vld_q;
    out_cmd_d = out_cmd_q;
    rr_ptr_d  = rr_ptr_q;
    if (load) begin
      out_vld_d = 1'b1;
      out_cmd_d = bus.ent_cmd_r[sel_idx];
      rr_ptr_d  = (sel_idx == PTR_W'(N - 1)) ? '0 : sel_idx + PTR_W'(1);
    end else if (bus.out_rdy) begin
      out_vld_d = 1'b0;
    end
  end

  always_comb begin
    unique case ({alloc, dealloc})
      2'b10:   occ_d = occ_q + CNT_W'(1);
      2'b01:   occ_d = occ_q - CNT_W'(1);
      default: occ_d = occ_q;
    endcase
    full_d  = (occ_d == CNT_W'(N));
    empty_d = (occ_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld_q <= 1'b0;
      out_cmd_q <= '0;
      rr_ptr_q  <= '0;
      occ_q     <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
    end else begin
      out_vld_q <= out_vld_d;
      out_cmd_q <= out_cmd_d;
      rr_ptr_q  <= rr_ptr_d;
      occ_q     <= occ_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
    end
  end

  // The counter must track the entry bank exactly; drifting past either end means they disagree.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(alloc && !dealloc && occ_q == CNT_W'(N)))
        else $error("occupancy overflow");
      assert (!(dealloc && !alloc && occ_q == '0))
        else $error("occupancy underflow");
    end
  end

  assign bus.out_vld = out_vld_q;
  assign bus.out_cmd = out_cmd_q;
  assign occ_r       = occ_q;
  assign full_r      = full_q;
  assign empty_r     = empty_q;

endmodule

// File: tb/tb_ob_cn_table_sched.sv
// Directed bench for the conditional-table controller with a behavioural
// entry bank (IDLE -> ACTIVE -> MATURED) whose maturity is triggered by the bench.
module tb_ob_cn_table_sched;
  import ob_pkg::*;

  localparam int N = 4;
  localparam logic [1:0] ST_IDLE = 2'd0, ST_ACT = 2'd1, ST_MTR = 2'd2;

  logic       clk;
  logic       rst;
  logic [2:0] occ_r;
  logic       full_r;
  logic       empty_r;

  int passCount  = 0;
  int checkCount = 0;

  logic [1:0]   entSt   [N];
  cmd_t         entHeld [N];
  logic [N-1:0] trig;
  cmd_t         expCmd;

  ob_cn_table_sched_if #(.N(N)) bus ();

  ob_cn_table_sched #(.N(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.master),
    .occ_r   (occ_r),
    .full_r  (full_r),
    .empty_r (empty_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic cmd_t mk(op_t op, int id);
    cmd_t c;
    c.op    = op;
    c.id    = 16'(id);
    c.price = 32'(id * 100);
    c.qty   = 16'(id + 7);
    return c;
  endfunction

  function automatic cmd_t conv(cmd_t c);
    cmd_t r;
    r = c;
    case (c.op)
      OP_BUY_STOP_LOSS:   r.op = OP_BUY_MARKET;
      OP_SELL_STOP_LOSS:  r.op = OP_SELL_MARKET;
      OP_BUY_STOP_LIMIT:  r.op = OP_BUY_LIMIT;
      OP_SELL_STOP_LIMIT: r.op = OP_SELL_LIMIT;
      default:            r.op = c.op;
    endcase
    return r;
  endfunction

  // Entry bank model: allocation, bench-triggered maturity, deallocation.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        entSt[i] <= ST_IDLE;
      end else if (bus.ent_al_vld[i]) begin
        entSt[i]   <= ST_ACT;
        entHeld[i] <= conv(bus.ent_al_cmd);
      end else if (entSt[i] == ST_ACT && trig[i]) begin
        entSt[i] <= ST_MTR;
      end else if (entSt[i] == ST_MTR && bus.ent_dl_vld[i]) begin
        entSt[i] <= ST_IDLE;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      bus.ent_busy_r[i] = (entSt[i] != ST_IDLE);
      bus.ent_mtr_r[i]  = (entSt[i] == ST_MTR);
      bus.ent_cmd_r[i]  = entHeld[i];
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic vld, input cmd_t c);
    bus.in_vld = vld;
    bus.in_cmd = c;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.out_rdy = 1'b1;
    trig = '0;
    applyStimulus(1'b1, mk(OP_BUY_STOP_LOSS, 99));
    tick;
    tick;
    checkCount++; if (bus.ent_al_vld !== 4'b0000) $display("[TB] FAIL reset_al: got %b want 0000", bus.ent_al_vld); else passCount++;
    checkCount++; if (bus.ent_dl_vld !== 4'b0000) $display("[TB] FAIL reset_dl: got %b want 0000", bus.ent_dl_vld); else passCount++;
    checkCount++; if (bus.out_vld !== 1'b0) $display("[TB] FAIL reset_out_vld: got %b want 0", bus.out_vld); else passCount++;
    checkCount++; if (bus.out_cmd !== cmd_t'('0)) $display("[TB] FAIL reset_out_cmd: got %h want 0", bus.out_cmd); else passCount++;
    checkCount++; if (occ_r !== 3'd0) $display("[TB] FAIL reset_occ: got %0d want 0", occ_r); else passCount++;
    checkCount++; if (empty_r !== 1'b1 || full_r !== 1'b0) $display("[TB] FAIL reset_flags: got empty=%b full=%b want 1/0", empty_r, full_r); else passCount++;
    applyStimulus(1'b0, mk(OP_NOP, 0));
    rst = 1'b0;
    tick;
  endtask

  task automatic test_alloc_first;
    applyStimulus(1'b1, mk(OP_BUY_STOP_LOSS, 1));
    checkCount++; if (bus.ent_al_vld !== 4'b0001) $display("[TB] FAIL first_al: got %b want 0001", bus.ent_al_vld); else passCount++;
    checkCount++; if (bus.in_rdy !== 1'b1) $display("[TB] FAIL first_in_rdy: got %b want 1", bus.in_rdy); else passCount++;
    tick;
    applyStimulus(1'b0, mk(OP_NOP, 0));
    checkCount++; if (occ_r !== 3'd1 || empty_r !== 1'b0) $display("[TB] FAIL first_occ: got occ=%0d empty=%b want 1/0", occ_r, empty_r); else passCount++;
  endtask

  task automatic test_fill_and_free;
    op_t ops [3];
    ops[0] = OP_SELL_STOP_LOSS;
    ops[1] = OP_BUY_STOP_LIMIT;
    ops[2] = OP_SELL_STOP_LIMIT;
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(1'b1, mk(ops[k-1], k + 1));
      checkCount++; if (bus.ent_al_vld !== 4'(1 << k)) $display("[TB] FAIL fill_al_%0d: got %b want %b", k, bus.ent_al_vld, 4'(1 << k)); else passCount++;
      tick;
    end
    applyStimulus(1'b1, mk(OP_BUY_STOP_LOSS, 5));
    checkCount++; if (occ_r !== 3'd4 || full_r !== 1'b1) $display("[TB] FAIL full_occ: got occ=%0d full=%b want 4/1", occ_r, full_r); else passCount++;
    checkCount++; if (bus.in_rdy !== 1'b0 || bus.ent_al_vld !== 4'b0000) $display("[TB] FAIL full_block: got in_rdy=%b al=%b want 0/0000", bus.in_rdy, bus.ent_al_vld); else passCount++;
    trig = 4'b0100;
    tick;
    trig = '0;
    checkCount++; if (bus.ent_dl_vld !== 4'b0100 || bus.ent_al_vld !== 4'b0000) $display("[TB] FAIL full_dl: got dl=%b al=%b want 0100/0000", bus.ent_dl_vld, bus.ent_al_vld); else passCount++;
    tick;
    expCmd = conv(mk(OP_BUY_STOP_LIMIT, 3));
    checkCount++; if (bus.out_vld !== 1'b1 || bus.out_cmd !== expCmd) $display("[TB] FAIL full_reissue: got vld=%b cmd=%h want 1/%h", bus.out_vld, bus.out_cmd, expCmd); else passCount++;
    checkCount++; if (occ_r !== 3'd3 || bus.ent_al_vld !== 4'b0100) $display("[TB] FAIL freed_realloc: got occ=%0d al=%b want 3/0100", occ_r, bus.ent_al_vld); else passCount++;
    tick;
    applyStimulus(1'b0, mk(OP_NOP, 0));
    checkCount++; if (occ_r !== 3'd4 || full_r !== 1'b1 || bus.out_vld !== 1'b0) $display("[TB] FAIL refill: got occ=%0d full=%b vld=%b want 4/1/0", occ_r, full_r, bus.out_vld); else passCount++;
  endtask

  task automatic test_round_robin;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, mk((k % 2 == 0) ? OP_BUY_STOP_LOSS : OP_SELL_STOP_LIMIT, 20 + k));
      tick;
    end
    applyStimulus(1'b0, mk(OP_NOP, 0));
    trig = 4'b1010;
    tick;
    trig = '0;
    checkCount++; if (bus.ent_dl_vld !== 4'b0010) $display("[TB] FAIL rr_dl_first: got %b want 0010", bus.ent_dl_vld); else passCount++;
    tick;
    expCmd = conv(mk(OP_SELL_STOP_LIMIT, 21));
    checkCount++; if (bus.out_vld !== 1'b1 || bus.out_cmd !== expCmd) $display("[TB] FAIL rr_out_first: got vld=%b cmd=%h want 1/%h", bus.out_vld, bus.out_cmd, expCmd); else passCount++;
    checkCount++; if (bus.ent_dl_vld !== 4'b1000) $display("[TB] FAIL rr_dl_second: got %b want 1000", bus.ent_dl_vld); else passCount++;
    tick;
    expCmd = conv(mk(OP_SELL_STOP_LIMIT, 23));
    checkCount++; if (bus.out_vld !== 1'b1 || bus.out_cmd !== expCmd) $display("[TB] FAIL rr_out_second: got vld=%b cmd=%h want 1/%h", bus.out_vld, bus.out_cmd, expCmd); else passCount++;
    checkCount++; if (dut.rr_ptr_q !== 2'd0) $display("[TB] FAIL rr_ptr_wrap: got %0d want 0", dut.rr_ptr_q); else passCount++;
    checkCount++; if (occ_r !== 3'd2) $display("[TB] FAIL rr_occ: got %0d want 2", occ_r); else passCount++;
    tick;
    checkCount++; if (bus.out_vld !== 1'b0) $display("[TB] FAIL rr_drain: got vld=%b want 0", bus.out_vld); else passCount++;
  endtask

  task automatic test_backpressure;
    cmd_t heldCmd;
    bus.out_rdy = 1'b0;
    trig = 4'b0101;
    tick;
    trig = '0;
    checkCount++; if (bus.ent_dl_vld !== 4'b0001) $display("[TB] FAIL bp_dl_load: got %b want 0001", bus.ent_dl_vld); else passCount++;
    tick;
    heldCmd = conv(mk(OP_BUY_STOP_LOSS, 20));
    for (int c = 0; c < 3; c++) begin
      checkCount++; if (bus.out_vld !== 1'b1 || bus.out_cmd !== heldCmd) $display("[TB] FAIL bp_hold_%0d: got vld=%b cmd=%h want 1/%h", c, bus.out_vld, bus.out_cmd, heldCmd); else passCount++;
      checkCount++; if (bus.ent_dl_vld !== 4'b0000) $display("[TB] FAIL bp_no_dl_%0d: got %b want 0000", c, bus.ent_dl_vld); else passCount++;
      tick;
    end
    bus.out_rdy = 1'b1;
    #1;
    checkCount++; if (bus.ent_dl_vld !== 4'b0100) $display("[TB] FAIL bp_release_dl: got %b want 0100", bus.ent_dl_vld); else passCount++;
    tick;
    expCmd = conv(mk(OP_BUY_STOP_LOSS, 22));
    checkCount++; if (bus.out_vld !== 1'b1 || bus.out_cmd !== expCmd) $display("[TB] FAIL bp_next_cmd: got vld=%b cmd=%h want 1/%h", bus.out_vld, bus.out_cmd, expCmd); else passCount++;
    checkCount++; if (occ_r !== 3'd0 || empty_r !== 1'b1) $display("[TB] FAIL bp_empty: got occ=%0d empty=%b want 0/1", occ_r, empty_r); else passCount++;
    tick;
    checkCount++; if (bus.out_vld !== 1'b0) $display("[TB] FAIL bp_drain: got vld=%b want 0", bus.out_vld); else passCount++;
  endtask

  task automatic test_simultaneous;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, mk(OP_SELL_STOP_LOSS, 30 + k));
      tick;
    end
    applyStimulus(1'b0, mk(OP_NOP, 0));
    trig = 4'b0001;
    tick;
    trig = '0;
    checkCount++; if (bus.ent_dl_vld !== 4'b0001) $display("[TB] FAIL sim_pre_dl: got %b want 0001", bus.ent_dl_vld); else passCount++;
    tick;
    trig = 4'b0100;
    tick;
    trig = '0;
    applyStimulus(1'b1, mk(OP_BUY_STOP_LIMIT, 33));
    checkCount++; if (bus.ent_al_vld !== 4'b0001 || bus.ent_dl_vld !== 4'b0100) $display("[TB] FAIL sim_strobes: got al=%b dl=%b want 0001/0100", bus.ent_al_vld, bus.ent_dl_vld); else passCount++;
    checkCount++; if (bus.ent_al_cmd !== mk(OP_BUY_STOP_LIMIT, 33)) $display("[TB] FAIL sim_al_cmd: got %h want %h", bus.ent_al_cmd, mk(OP_BUY_STOP_LIMIT, 33)); else passCount++;
    tick;
    applyStimulus(1'b0, mk(OP_NOP, 0));
    expCmd = conv(mk(OP_SELL_STOP_LOSS, 32));
    checkCount++; if (occ_r !== 3'd2) $display("[TB] FAIL sim_occ: got %0d want 2", occ_r); else passCount++;
    checkCount++; if (bus.out_cmd !== expCmd) $display("[TB] FAIL sim_out_cmd: got %h want %h", bus.out_cmd, expCmd); else passCount++;
  endtask

  task automatic test_reset_mid;
    bus.out_rdy = 1'b0;
    applyStimulus(1'b1, mk(OP_SELL_STOP_LIMIT, 34));
    checkCount++; if (bus.ent_al_vld !== 4'b0100) $display("[TB] FAIL mid_al: got %b want 0100", bus.ent_al_vld); else passCount++;
    tick;
    checkCount++; if (occ_r !== 3'd3 || bus.out_vld !== 1'b1) $display("[TB] FAIL mid_pre: got occ=%0d vld=%b want 3/1", occ_r, bus.out_vld); else passCount++;
    rst = 1'b1;
    #1;
    checkCount++; if (bus.ent_al_vld !== 4'b0000 || bus.ent_dl_vld !== 4'b0000) $display("[TB] FAIL mid_rst_strobes: got al=%b dl=%b want 0000/0000", bus.ent_al_vld, bus.ent_dl_vld); else passCount++;
    tick;
    rst = 1'b0;
    applyStimulus(1'b0, mk(OP_NOP, 0));
    checkCount++; if (bus.out_vld !== 1'b0 || bus.out_cmd !== cmd_t'('0)) $display("[TB] FAIL mid_out: got vld=%b cmd=%h want 0/0", bus.out_vld, bus.out_cmd); else passCount++;
    checkCount++; if (occ_r !== 3'd0 || empty_r !== 1'b1 || full_r !== 1'b0) $display("[TB] FAIL mid_occ: got occ=%0d empty=%b full=%b want 0/1/0", occ_r, empty_r, full_r); else passCount++;
    checkCount++; if (dut.rr_ptr_q !== 2'd0) $display("[TB] FAIL mid_ptr: got %0d want 0", dut.rr_ptr_q); else passCount++;
    applyStimulus(1'b1, mk(OP_BUY_STOP_LOSS, 40));
    checkCount++; if (bus.ent_al_vld !== 4'b0001) $display("[TB] FAIL mid_realloc: got %b want 0001", bus.ent_al_vld); else passCount++;
    tick;
    applyStimulus(1'b0, mk(OP_NOP, 0));
  endtask

  initial begin
    #20000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1;
    trig = '0;
    bus.in_vld = 1'b0;
    bus.in_cmd = '0;
    bus.out_rdy = 1'b1;
    test_reset;
    test_alloc_first;
    test_fill_and_free;
    test_round_robin;
    test_backpressure;
    test_simultaneous;
    test_reset_mid;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/ob_cn_table_sched.md
# ob_cn_table_sched

Controller for the conditional-order table: the bank of N stop-order entry machines (IDLE -> ACTIVE -> MATURED). It allocates incoming stop commands to free entries, arbitrates round-robin among matured entries, and reissues each converted command (market/limit opcode) through a registered valid/ready port toward the matching engine. It deallocates each entry as its command is taken. It sits between the command dispatcher and the entry bank and owns the al_vld/dl_vld strobes of every entry.

## Interface
- N, default 4: number of conditional entries (2..16)
- CNT_W, default $clog2(N+1): occupancy counter width

- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_vld  in  1  stop command offered
- in_cmd  in  ob_pkg::cmd_t  offered command (opcode already Buy/Sell StopLoss/StopLimit)
- in_rdy  out  1  at least one entry free
- ent_busy_r  in  N  per-entry registered busy
- ent_mtr_r  in  N  per-entry registered matured
- ent_cmd_r  in  N x ob_pkg::cmd_t  per-entry held (converted) command
- ent_al_vld  out  N  one-hot allocation strobe
- ent_al_cmd  out  ob_pkg::cmd_t  command broadcast to all entries (= in_cmd)
- ent_dl_vld  out  N  one-hot deallocation strobe
- out_vld  out  1  reissued command valid (registered)
- out_cmd  out  ob_pkg::cmd_t  reissued command (registered)
- out_rdy  in  1  downstream accepts
- occ_r  out  CNT_W  entries currently busy
- full_r / empty_r  out  1  occ_r == N / occ_r == 0

## Operation
- Allocation: in_rdy = |~ent_busy_r (combinational). When in_vld & in_rdy, ent_al_vld = one-hot of lowest-index entry with ent_busy_r == 0, otherwise zero. ent_al_cmd = in_cmd always.
- Arbitration: rr_ptr_r (log2 N bits) marks the highest-priority index. sel = first i in rr_ptr_r, rr_ptr_r+1, ... (mod N) with ent_mtr_r[i] set.
- Output stage: load = (any matured) & (~out_vld_r | out_rdy).
  - On load: out_cmd_r <= ent_cmd_r[sel]; out_vld_r <= 1; ent_dl_vld[sel] = 1 (same cycle); rr_ptr_r <= (sel+1) mod N.
  - Else if out_rdy: out_vld_r <= 0.
- The entry sees dl_vld while MATURED, so ent_mtr_r and ent_busy_r drop next cycle. The entry is not reselected because selection uses registered state.
- Occupancy: +1 on allocation, -1 on deallocation, unchanged when both happen in the same cycle. Never wraps past N or below 0; an attempt to do so is an assertion failure.
- Entries outside the selected index receive no strobes. At most one al and one dl per cycle. al and dl never target the same entry, because al targets only non-busy entries.

## Timing
- Reset: out_vld_r=0, out_cmd_r=0, rr_ptr_r=0, occ_r=0, empty_r=1, full_r=0. ent_al_vld/ent_dl_vld are 0 while rst is high.
- Allocation: entry busy visible 1 cycle after the in_vld&in_rdy edge.
- Reissue latency: ent_mtr_r high in cycle t with an idle output -> out_vld high in t+1. Throughput is 1 command/cycle with out_rdy held high.
- Backpressure: while out_vld_r & ~out_rdy, out_cmd_r holds and no dl_vld is issued. Matured entries wait.
- Full: in_rdy=0; in_vld is held by upstream. An entry freed in cycle t is allocatable in t+1.
- Reset mid-operation clears all control state. The entry bank shares rst and resets to IDLE in the same cycle.

## Structure
- ob_pkg: cmd_t (existing); add CN_TABLE_N_DEFAULT.
- Sub-module ob_cn_rr_arb: parameterised N-way rotating-priority arbiter. Inputs are the request vector and pointer; outputs are a one-hot grant and an encoded index.
- Lowest-free-index allocation uses a plain priority encoder in-line. No sub-module.

## Test plan
- Reset then in_vld with cmd BuyStopLoss, all free -> ent_al_vld=4'b0001 same cycle; occ_r=1 next cycle, empty_r=0.
- Fill all 4 entries -> full_r=1, in_rdy=0. A fifth in_vld gets no al strobe until one entry is reissued; it then allocates the freed index 1 cycle after dl.
- ent_mtr_r=4'b1010 in the same cycle, out_rdy=1 -> reissue entry 1, then entry 3 on consecutive cycles. dl_vld=4'b0010 then 4'b1000, rr_ptr_r ends at 0.
- out_rdy=0 for 3 cycles with out_vld=1 -> out_cmd stable, no dl_vld. Release -> next matured entry loads in the same cycle as acceptance.
- Simultaneous allocation into entry 0 and dealloc of entry 2 -> occ_r unchanged.
- Assert rst with out_vld=1 and occ_r=3 -> next cycle all outputs at reset values.
